// File: rtl/servo_pwm_pkg.sv
// Shared constants and width helpers for the multi-channel servo PWM.
// Optional ramping of pulse width is enabled with SERVO_PWM_RAMP_EN.
package servo_pwm_pkg;

  localparam int DEF_NCH       = 4;
  localparam int DEF_CNT_W     = 20;
  localparam int DEF_PERIOD    = 1000000;
  localparam int DEF_PW_MIN    = 50000;
  localparam int DEF_PW_MAX    = 100000;
  localparam int DEF_PW_INIT   = 75000;
  localparam int DEF_RAMP_STEP = 500;

  function automatic logic [31:0] clamp(
    input logic [31:0] v,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // A zero width only exists straight after reset, so jump there directly.
  function automatic logic [31:0] ramp_step(
    input logic [31:0] cur,
    input logic [31:0] tgt,
    input logic [31:0] step
  );
    if (cur == '0) return tgt;
    if (tgt > cur) return (tgt - cur > step) ? cur + step : tgt;
    return (cur - tgt > step) ? cur - step : tgt;
  endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: target/active width, frame enable latch, compare.
// With SERVO_PWM_RAMP_EN the active width slews toward the target.
module servo_pwm_ch
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PW_INIT   = DEF_PW_INIT,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  input  logic             load,
  input  logic             en_in,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] active;
  logic             en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target <= CNT_W'(PW_INIT);
      active <= '0;
      en     <= 1'b0;
      pwm    <= 1'b0;
    end else begin
      if (wr)
        target <= wr_val;
      if (load) begin
`ifdef SERVO_PWM_RAMP_EN
        active <= CNT_W'(ramp_step(32'(active),
                                   32'(target),
                                   32'(RAMP_STEP)));
`else
        active <= target;
`endif
        en <= en_in;
      end
      pwm <= en && (cnt < active);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: shared frame counter and write decode.
// Define SERVO_PWM_RAMP_EN to slew widths by RAMP_STEP per frame.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int PW_MIN    = DEF_PW_MIN,
  parameter int PW_MAX    = DEF_PW_MAX,
  parameter int PW_INIT   = DEF_PW_INIT,
  parameter int RAMP_STEP = DEF_RAMP_STEP,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [CNT_W-1:0] wr_data,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   pwm,
  output logic             frame_start
);

  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             wr_ok;
  logic [CNT_W-1:0] wr_val;

  assign load   = (cnt == CNT_W'(PERIOD - 1));
  assign wr_ok  = wr_en && (32'(wr_ch) < NCH);
  assign wr_val = CNT_W'(clamp(32'(wr_data),
                               32'(PW_MIN),
                               32'(PW_MAX)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= load ? '0 : cnt + 1'b1;
      frame_start <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    servo_pwm_ch #(
      .CNT_W    (CNT_W),
      .PW_INIT  (PW_INIT),
      .RAMP_STEP(RAMP_STEP)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .wr    (wr_ok && (wr_ch == CHW'(i))),
      .wr_val(wr_val),
      .load  (load),
      .en_in (ch_en[i]),
      .cnt   (cnt),
      .pwm   (pwm[i])
    );
  end

  // A pulse as long as the frame would never drop between frames.
  cfg_ok: assert property (@(posedge clk) PW_MAX < PERIOD)
    else $error("servo_pwm_multi: PW_MAX must be below PERIOD");

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Frame-level scoreboard bench for servo_pwm_multi.
// Expected widths are queued per frame and checked at the next frame.
module tb_servo_pwm_multi;

  localparam int PERIOD = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [19:0] wr_data = '0;
  logic [3:0] ch_en = 4'hF;
  logic [3:0] pwm;
  logic       frame_start;

  logic [2:0] wr_ch2 = 3'd5;
  logic [4:0] ch_en2 = 5'h1F;
  logic [4:0] pwm2;
  logic       frame_start2;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NCH(4), .CNT_W(20), .PERIOD(PERIOD),
    .PW_MIN(10), .PW_MAX(40), .PW_INIT(20),
    .RAMP_STEP(5)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data),
    .ch_en(ch_en), .pwm(pwm),
    .frame_start(frame_start)
  );

  servo_pwm_multi #(
    .NCH(5), .CNT_W(20), .PERIOD(PERIOD),
    .PW_MIN(10), .PW_MAX(40), .PW_INIT(20),
    .RAMP_STEP(5)
  ) dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en),
    .wr_ch(wr_ch2), .wr_data(wr_data),
    .ch_en(ch_en2), .pwm(pwm2),
    .frame_start(frame_start2)
  );

  typedef struct packed {
    logic [3:0][7:0] w;
    logic [7:0]      w2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   spos = 0;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic push(input int a, input int b, input int c,
                      input int d, input int w2);
    exp_t e;
    e.w[0] = 8'(a);
    e.w[1] = 8'(b);
    e.w[2] = 8'(c);
    e.w[3] = 8'(d);
    e.w2   = 8'(w2);
    exp_q.push_back(e);
  endtask

  // Monitor: measures each frame and scores it against the queue.
  int fnum = 0;
  int fcyc;
  bit in_frame = 0;
  int tot[4];
  int run[4];
  bit lows[4];
  int tot2;

  task automatic end_frame();
    exp_t e;
    int m;
    fnum++;
    check($sformatf("f%0d_period", fnum), fcyc, PERIOD);
    if (exp_q.size() == 0) begin
      check($sformatf("f%0d_queue", fnum), 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      m = (tot[i] == run[i]) ? run[i] : 999;
      check($sformatf("f%0d_ch%0d", fnum, i), m, int'(e.w[i]));
    end
    check($sformatf("f%0d_dut2", fnum), tot2, 5 * int'(e.w2));
  endtask

  initial begin : mon
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_frame = 0;
      end else begin
        if (frame_start) begin
          if (in_frame) end_frame();
          in_frame = 1;
          fcyc = 0;
          tot2 = 0;
          for (int i = 0; i < 4; i++) begin
            tot[i] = 0;
            run[i] = 0;
            lows[i] = 0;
          end
        end
        if (in_frame) begin
          fcyc++;
          tot2 += $countones(pwm2);
          for (int i = 0; i < 4; i++) begin
            if (pwm[i]) begin
              tot[i]++;
              if (!lows[i]) run[i]++;
            end else begin
              lows[i] = 1;
            end
          end
        end
      end
    end
  end

  task automatic wait_fs();
    bit seen = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("fs_timeout", 0, 1);
    spos = 1;
  endtask

  task automatic goto(input int p);
    while (spos < p) begin
      @(negedge clk);
      spos++;
    end
  endtask

  task automatic wr(input int ch, input int d);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_data = 20'(d);
    @(negedge clk);
    spos++;
    wr_en   = 1'b0;
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    check("rst_pwm", int'(pwm), 0);
    check("rst_fs", int'(frame_start), 0);
    reset = 1'b1;
    @(negedge clk);
    check("fs_first", int'(frame_start), 1);
    spos = 1;
    push(0, 0, 0, 0, 0);
    wait_fs();
    push(20, 20, 20, 20, 20);
`ifdef SERVO_PWM_RAMP_EN
    goto(50);
    wr(0, 38);
    wait_fs();
    push(25, 20, 20, 20, 20);
    wait_fs();
    push(30, 20, 20, 20, 20);
    wait_fs();
    push(35, 20, 20, 20, 20);
    wait_fs();
    push(38, 20, 20, 20, 20);
`else
    goto(50);
    wr(1, 3);
    wr(2, 90);
    wait_fs();
    push(20, 10, 40, 20, 20);
    goto(99);
    wr(0, 30);
    wait_fs();
    push(20, 10, 40, 20, 20);
    wait_fs();
    push(30, 10, 40, 20, 20);
    goto(5);
    ch_en = 4'h7;
    wait_fs();
    push(30, 10, 40, 0, 20);
`endif
    goto(12);
    check("mid_pulse", int'(pwm[0]), 1);
    reset = 1'b0;
    #1;
    check("rst_async", int'(pwm), 0);
    exp_q.delete();
    ch_en = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("restart_fs", int'(frame_start), 1);
    spos = 1;
    push(0, 0, 0, 0, 0);
    wait_fs();
    push(20, 20, 20, 20, 20);
    wait_fs();
    push(20, 20, 20, 20, 20);
    wait_fs();
    @(negedge clk);
    check("q_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
